uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter F_CLK, default 12000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate in bit/s; divider DIV = F_CLK/BAUD (integer truncation), DIV >= 2.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port n_reset, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port sel, input, 1, meaning bus access to this peripheral this cycle.
REQ-006 SHALL have port adr, input, 1, meaning register select: 0 = DATA (offset 0x0), 1 = STATUS (offset 0x4).
REQ-007 SHALL have port wren, input, 4, meaning byte write enables; a write occurs when sel=1 and wren[0]=1.
REQ-008 SHALL have port di, input, 32, meaning write data; only di[7:0] is used.
REQ-009 SHALL have port do, output, 32, meaning registered read data.
REQ-010 SHALL have port tx, output, 1, meaning serial line, idle high.

Function
REQ-011 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit lasts exactly DIV clocks.
REQ-012 SHALL implement a transmitter FSM with states IDLE, START, DATA, STOP; IDLE->START on pending byte, START->DATA after DIV clocks, DATA->STOP after 8th bit, STOP->IDLE or ->START (pending byte) after DIV clocks.
REQ-013 SHALL drive tx low on the clock after a DATA write is accepted while FSM is IDLE with no pending byte (latency 1 cycle).
REQ-014 SHALL accept a DATA write only when space is available (STATUS bit3 = 1); writes with no space SHALL be silently dropped.
REQ-015 SHALL start the next pending frame on the cycle immediately after the previous stop bit ends (no idle gap).
REQ-016 SHALL return STATUS = {28'b0, space, 1'b0, idle, 1'b0}: bit1 idle = FSM IDLE and nothing pending; bit3 space = a byte can be accepted; all other bits 0.
REQ-017 SHALL return DATA reads as 32'h0.
REQ-018 SHALL update do one cycle after a cycle with sel=1 and wren=0; do SHALL hold its value otherwise.
REQ-019 SHALL evaluate STATUS on the same edge a write is accepted so that a read in the following cycle already reports idle=0.
REQ-020 SHALL use a baud counter of width clog2(DIV) that reloads at each bit boundary and is held at 0 in IDLE.

Reset
REQ-021 SHALL, while n_reset=0 on a rising edge, force: FSM IDLE, tx=1, baud and bit counters 0, holding/FIFO empty, do=0.
REQ-022 SHALL abort a frame in progress on reset; tx returns high on the clock edge where reset is sampled; aborted and pending bytes are lost.

Configuration
REQ-023 SHALL, with macro UART_TX_FIFO_EN defined, buffer pending bytes in a 4-entry FIFO; space=1 while fewer than 4 entries held.
REQ-024 SHALL, without UART_TX_FIFO_EN, use a single holding register; space=1 while it is empty.
REQ-025 SHALL have identical register map, frame timing and reset behaviour in both configurations.

Structure
REQ-026 SHALL place register offsets (DATA 0x0, STATUS 0x4), STATUS bit positions and FIFO depth constant in shared package uart_pkg.
REQ-027 SHALL implement the FIFO as sub-module uart_tx_fifo (synchronous, same clk/n_reset, push/pop/full/empty), instantiated only under UART_TX_FIFO_EN.

Verification
REQ-028 SHALL cover: F_CLK=12000000, BAUD=1000000 (DIV=12), write 0x61 -> tx low 12 clocks from next cycle, then bits 1,0,0,0,0,1,1,0 each 12 clocks, stop high; frame 120 clocks.
REQ-029 SHALL cover: poll STATUS during REQ-028 frame -> reads 0x0 (FIFO build 0x8) while transmitting, 0x2|0x8=0xA once idle after 120 clocks.
REQ-030 SHALL cover: without FIFO, write 0x41, 0x42, 0x43 back-to-back -> 0x41 then 0x42 sent with no gap (240 clocks), 0x43 dropped.
REQ-031 SHALL cover: with UART_TX_FIFO_EN, write 6 bytes back-to-back -> first 5 sent contiguously (1 in shift, 4 queued), 6th dropped.
REQ-032 SHALL cover: assert n_reset=0 at clock 50 of a frame -> tx=1 next edge, STATUS reads 0xA after release, no further bits emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmitter slice: register offsets, the
// address-bit encoding derived from them, STATUS bit positions, the FIFO depth
// used by the optional FIFO build, transmitter FSM state codes and a helper
// that assembles the STATUS word.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Byte offsets of the two registers; the single adr bit selects between them
    localparam logic [31:0] DATA_OFFSET   = 32'h0;
    localparam logic [31:0] STATUS_OFFSET = 32'h4;
    localparam logic        ADR_DATA      = DATA_OFFSET[2];
    localparam logic        ADR_STATUS    = STATUS_OFFSET[2];

    // STATUS bit positions
    localparam int STATUS_IDLE_BIT  = 1;
    localparam int STATUS_SPACE_BIT = 3;

    // Number of queued bytes in the FIFO build
    localparam int FIFO_DEPTH = 4;

    // Transmitter FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic logic [31:0] status_word(input logic idle, input logic space);
        logic [31:0] w;
        w                   = '0;
        w[STATUS_IDLE_BIT]  = idle;
        w[STATUS_SPACE_BIT] = space;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Register bus between a bus master and the UART transmitter.
//   sel  : access to the peripheral this cycle
//   adr  : register select, 0 = DATA, 1 = STATUS
//   wren : byte write enables, a write needs wren[0]
//   di   : write data, only di[7:0] is meaningful
//   dout : registered read data (the peripheral's "do" output)
// -----------------------------------------------------------------------------
interface uart_tx_if;
    logic        sel;
    logic        adr;
    logic [3:0]  wren;
    logic [31:0] di;
    logic [31:0] dout;

    modport master (output sel, adr, wren, di, input dout);
    modport slave  (input sel, adr, wren, di, output dout);
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO holding bytes waiting for the transmitter. Only compiled
// when UART_TX_FIFO_EN is defined, since only that build instantiates it.
//   clk, n_reset : system clock, synchronous active-low reset
//   push, din    : enqueue din (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   dout         : head entry
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; explicit wrap keeps non power-of-two depths correct
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty flag guards stale contents
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule
`endif

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Memory-mapped 8N1 UART transmitter. Each bit lasts DIV = F_CLK/BAUD clocks.
//   clk     : system clock, rising edge
//   n_reset : synchronous active-low reset
//   bus     : register bus (uart_tx_if.slave): DATA write queues a byte,
//             STATUS read returns {space, 0, idle, 0} in bits [3:0]
//   tx      : serial line, idle high
// Build option UART_TX_FIFO_EN: queue pending bytes in a 4-entry FIFO instead
// of a single holding register.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int F_CLK = 12000000,
    parameter int BAUD  = 115200
) (
    input  logic     clk,
    input  logic     n_reset,
    uart_tx_if.slave bus,
    output logic     tx
);

    localparam int            DIV       = F_CLK / BAUD;
    localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          bit_end;
    logic          stop_done;
    logic          pending;
    logic [7:0]    pend_data;
    logic          pop;
    logic          push;
    logic          space;
    logic          idle;
    logic          unused_di;

    assign unused_di = ^bus.di[31:8];

    // A pending byte is taken either from IDLE or straight at the end of a
    // stop bit, so back-to-back frames have no gap between them
    assign bit_end   = (state != ST_IDLE) && (baud_cnt == BAUD_LAST);
    assign stop_done = (state == ST_STOP) && bit_end;
    assign pop       = pending && ((state == ST_IDLE) || stop_done);
    assign push      = bus.sel && bus.wren[0] && (bus.adr == ADR_DATA) && space;
    assign idle      = (state == ST_IDLE) && !pending;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .din     (bus.di[7:0]),
        .pop     (pop),
        .dout    (pend_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pending = !fifo_empty;
    assign space   = !fifo_full;
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    // The holding register is counted as occupied for the whole frame, so a
    // second byte fits only while the transmitter is idle or is just taking
    // the held byte, which is when the register is refilled
    assign pending   = hold_valid;
    assign pend_data = hold_data;
    assign space     = (state == ST_IDLE) || pop;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= bus.di[7:0];
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // Transmitter FSM; tx is registered so a bit changes exactly on its boundary
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= 8'h00;
            tx       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        state   <= ST_START;
                        shift_q <= pend_data;
                        tx      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                        tx       <= shift_q[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state   <= ST_START;
                            shift_q <= pend_data;
                            tx      <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Read data is registered and only refreshed by a read access (no byte
    // enables); STATUS already reflects a write accepted on the previous edge
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            bus.dout <= 32'h0;
        end else if (bus.sel && (bus.wren == 4'b0000)) begin
            bus.dout <= (bus.adr == ADR_STATUS) ? status_word(idle, space) : 32'h0;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx at F_CLK = 12 MHz, BAUD = 1 Mbit/s (DIV 12).
// Register accesses come from a vector table; frames are compared cycle by
// cycle against hand-written 10-bit line patterns (bit 0 = start bit).
// -----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DIV   = 12;
    localparam int FRAME = 10 * DIV;

`ifdef UART_TX_FIFO_EN
    localparam logic [31:0] BUSY_STATUS = 32'h8;
`else
    localparam logic [31:0] BUSY_STATUS = 32'h0;
`endif

    typedef struct {
        logic        sel;
        logic        adr;
        logic [3:0]  wren;
        logic [31:0] di;
        logic [31:0] exp_do;
        logic        exp_tx;
    } reg_vec_t;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } frame_vec_t;

    logic clk;
    logic n_reset;
    logic tx;
    int   checks;
    int   errors;

    logic [7:0] wr_list  [6];
    logic [9:0] exp_list [6];

    reg_vec_t   reg_vecs   [10];
    frame_vec_t frame_vecs [4];

    uart_tx_if bus_if ();

    uart_tx #(
        .F_CLK (12000000),
        .BAUD  (1000000)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus_if),
        .tx      (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic a, input logic [3:0] w,
                                 input logic [31:0] d);
        bus_if.sel  = s;
        bus_if.adr  = a;
        bus_if.wren = w;
        bus_if.di   = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Writes wr_list[0..n_wr-1] on consecutive cycles, then keeps reading
    // STATUS while checking tx every cycle against exp_list[0..n_exp-1]
    task automatic runSequence(input int n_wr, input int n_exp, input bit check_busy,
                               input string tag);
        int   total;
        int   t;
        int   f;
        int   pos;
        logic exp_bit;
        total = 1 + FRAME * n_exp + 130;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (k < n_wr) applyStimulus(1'b1, 1'b0, 4'b0001, {24'h0, wr_list[k]});
            else          applyStimulus(1'b1, 1'b1, 4'b0000, 32'h0);
            @(posedge clk);
            #1;
            if (k == 0) begin
                checkOutput($sformatf("%s_latency", tag), 32'(tx), 32'h1);
            end else begin
                t = k - 1;
                f = t / FRAME;
                if (f < n_exp) begin
                    pos     = t % FRAME;
                    exp_bit = exp_list[f][pos / DIV];
                    checkOutput($sformatf("%s_f%0d_b%0d_c%0d", tag, f, pos / DIV, pos % DIV),
                                32'(tx), 32'(exp_bit));
                    if (check_busy && ((pos % DIV) == DIV / 2) && (k > n_wr)) begin
                        checkOutput($sformatf("%s_busy_status_b%0d", tag, pos / DIV),
                                    bus_if.dout, BUSY_STATUS);
                    end
                end else begin
                    checkOutput($sformatf("%s_idle_tx", tag), 32'(tx), 32'h1);
                end
            end
        end
        checkOutput($sformatf("%s_idle_status", tag), bus_if.dout, 32'hA);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] uart_tx bench, DIV=%0d, FIFO depth constant %0d", DIV, FIFO_DEPTH);

        reg_vecs[0] = '{1'b1, 1'b1, 4'b0000, 32'h0,  32'hA, 1'b1};
        reg_vecs[1] = '{1'b1, 1'b0, 4'b0000, 32'h0,  32'h0, 1'b1};
        reg_vecs[2] = '{1'b0, 1'b1, 4'b0000, 32'h0,  32'h0, 1'b1};
        reg_vecs[3] = '{1'b1, 1'b1, 4'b0000, 32'h0,  32'hA, 1'b1};
        reg_vecs[4] = '{1'b1, 1'b1, 4'b0001, 32'h55, 32'hA, 1'b1};
        reg_vecs[5] = '{1'b0, 1'b0, 4'b0001, 32'h55, 32'hA, 1'b1};
        reg_vecs[6] = '{1'b1, 1'b0, 4'b1110, 32'h55, 32'hA, 1'b1};
        reg_vecs[7] = '{1'b1, 1'b1, 4'b0000, 32'h0,  32'hA, 1'b1};
        reg_vecs[8] = '{1'b1, 1'b0, 4'b0000, 32'h0,  32'h0, 1'b1};
        reg_vecs[9] = '{1'b0, 1'b1, 4'b0000, 32'h0,  32'h0, 1'b1};

        frame_vecs[0] = '{8'h61, 10'b1_0110_0001_0};
        frame_vecs[1] = '{8'h00, 10'b1_0000_0000_0};
        frame_vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
        frame_vecs[3] = '{8'hA5, 10'b1_1010_0101_0};

        // Reset, with a read pending to show do is held at zero
        n_reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'b0000, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", 32'(tx), 32'h1);
        checkOutput("reset_do", bus_if.dout, 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0);

        // Register access table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            applyStimulus(reg_vecs[i].sel, reg_vecs[i].adr, reg_vecs[i].wren, reg_vecs[i].di);
            @(posedge clk);
            #1;
            checkOutput($sformatf("reg_vec%0d_do", i), bus_if.dout, reg_vecs[i].exp_do);
            checkOutput($sformatf("reg_vec%0d_tx", i), 32'(tx), 32'(reg_vecs[i].exp_tx));
        end

        // Single frames with STATUS polled during and after
        for (int i = 0; i < 4; i++) begin
            wr_list[0]  = frame_vecs[i].data;
            exp_list[0] = frame_vecs[i].frame;
            runSequence(1, 1, 1'b1, $sformatf("frame_%02h", frame_vecs[i].data));
        end

`ifdef UART_TX_FIFO_EN
        // Six back-to-back writes: five fit (one shifting, four queued)
        for (int i = 0; i < 6; i++) wr_list[i] = 8'h10 + 8'(i);
        exp_list[0] = {1'b1, 8'h10, 1'b0};
        exp_list[1] = {1'b1, 8'h11, 1'b0};
        exp_list[2] = {1'b1, 8'h12, 1'b0};
        exp_list[3] = {1'b1, 8'h13, 1'b0};
        exp_list[4] = {1'b1, 8'h14, 1'b0};
        runSequence(6, 5, 1'b0, "fifo_burst");
`else
        // Three back-to-back writes: two frames with no gap, third dropped
        wr_list[0]  = 8'h41;
        wr_list[1]  = 8'h42;
        wr_list[2]  = 8'h43;
        exp_list[0] = {1'b1, 8'h41, 1'b0};
        exp_list[1] = {1'b1, 8'h42, 1'b0};
        runSequence(3, 2, 1'b0, "hold_burst");
`endif

        // Reset 50 clocks into a frame of 0x61 (tx is on data bit 3, low)
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'b0001, 32'h61);
        @(posedge clk);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b1, 4'b0000, 32'h0);
            @(posedge clk);
        end
        #1;
        checkOutput("abort_midframe_tx", 32'(tx), 32'h0);
        @(negedge clk);
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_reset_tx", 32'(tx), 32'h1);
        checkOutput("abort_reset_do", bus_if.dout, 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_status", bus_if.dout, 32'hA);
        for (int k = 0; k < 150; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("abort_quiet_c%0d", k), 32'(tx), 32'h1);
        end
        checkOutput("abort_status_end", bus_if.dout, 32'hA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
